accum_n: RTL and testbench

//  Parametrised N-bit add/subtract accumulator for the DE-series demos. Takes an operand B,

---
 rtl/accum_pkg.sv | 8 +
 rtl/addsub_n.sv | 16 +
 rtl/accum_n.sv | 94 +++++++++
 tb/tb_accum_n.sv | 114 +++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// accum_pkg: opcode and FSM state encodings shared by the accumulator.
package accum_pkg;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_EXEC = 2'b01, S_DONE = 2'b10} state_t;
endpackage

// File: rtl/addsub_n.sv
// addsub_n: combinational N-bit adder/subtractor with carry (no-borrow) and signed overflow.
module addsub_n #(parameter int N = 4) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Sub,
  output logic [N-1:0] S,
  output logic         Cout,
  output logic         Ovf
);
  logic [N-1:0] bop;
  always_comb begin
    bop = Sub ? ~B : B;
    {Cout, S} = {1'b0, A} + {1'b0, bop} + {{N{1'b0}}, Sub};
    Ovf = (A[N-1] == bop[N-1]) & (S[N-1] != A[N-1]);
  end
endmodule

// File: rtl/accum_n.sv
// accum_n: start-triggered add/sub/load/clear accumulator with overflow flags and optional saturation.
module accum_n import accum_pkg::*; #(parameter int N = 4) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Start,
  input  logic [1:0]   Op,
  input  logic         Sat,
  input  logic [N-1:0] B,
  output logic [N-1:0] Acc,
  output logic         Cout,
  output logic         Ovf,
  output logic         OvfSticky,
  output logic         Busy,
  output logic         Done
);
  state_t       state_q, state_d;
  logic         start_q;
  logic [1:0]   op_q, op_d;
  logic         sat_q, sat_d;
  logic [N-1:0] b_q, b_d;
  logic [N-1:0] acc_q, acc_d;
  logic         cout_q, cout_d, ovf_q, ovf_d, sticky_q, sticky_d;
  logic [N-1:0] as_s;
  logic         as_cout, as_ovf, rise;
  addsub_n #(.N(N)) u_addsub (
    .A(acc_q), .B(b_q), .Sub(op_q == OP_SUB), .S(as_s), .Cout(as_cout), .Ovf(as_ovf)
  );
  assign rise = Start & ~start_q;
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sat_d    = sat_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    sticky_d = sticky_q;
    if (state_q == S_IDLE && rise) begin
      state_d = S_EXEC;
      op_d    = Op;
      sat_d   = Sat;
      b_d     = B;
    end else if (state_q == S_EXEC) begin
      state_d = S_DONE;
      if (op_q == OP_LOAD) begin
        acc_d  = b_q;
        cout_d = 1'b0;
        ovf_d  = 1'b0;
      end else if (op_q == OP_CLR) begin
        acc_d    = '0;
        cout_d   = 1'b0;
        ovf_d    = 1'b0;
        sticky_d = 1'b0;
      end else begin
        // saturate toward the sign of the old accumulator; flags keep the raw result
        acc_d    = (sat_q && as_ovf) ? (acc_q[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}}) : as_s;
        cout_d   = as_cout;
        ovf_d    = as_ovf;
        sticky_d = sticky_q | as_ovf;
      end
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      op_q     <= '0;
      sat_q    <= 1'b0;
      b_q      <= '0;
      acc_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= Start;
      op_q     <= op_d;
      sat_q    <= sat_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      sticky_q <= sticky_d;
    end
  end
  assign Acc       = acc_q;
  assign Cout      = cout_q;
  assign Ovf       = ovf_q;
  assign OvfSticky = sticky_q;
  assign Busy      = state_q == S_EXEC;
  assign Done      = state_q == S_DONE;
endmodule

// File: tb/tb_accum_n.sv
// tb_accum_n: directed vectors with hand-computed results for the N=4 accumulator.
module tb_accum_n;
  logic       clk = 1'b0;
  logic       rst, start, sat;
  logic [1:0] op;
  logic [3:0] b, acc;
  logic       cout, ovf, sticky, busy, done;
  int         n_chk = 0, n_pass = 0;
  accum_n #(.N(4)) dut (
    .Clock(clk), .Reset(rst), .Start(start), .Op(op), .Sat(sat), .B(b),
    .Acc(acc), .Cout(cout), .Ovf(ovf), .OvfSticky(sticky), .Busy(busy), .Done(done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic do_op(input logic [1:0] o, input logic [3:0] v, input logic s);
    int cyc;
    @(negedge clk);
    op = o; b = v; sat = s; start = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while (!done && cyc < 10);
    if (!done) check("op_timeout", done, 1);
    @(negedge clk);
    start = 1'b0;
  endtask
  initial begin
    int pulses, lat;
    rst = 1'b1; start = 1'b0; op = 2'b00; sat = 1'b0; b = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_acc", acc, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_sticky", sticky, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk); rst = 1'b0;
    do_op(2'b10, 4'h5, 0); do_op(2'b00, 4'h3, 0);
    check("add53_acc", acc, 4'h8);
    check("add53_cout", cout, 0);
    check("add53_ovf", ovf, 1);
    check("add53_sticky", sticky, 1);
    do_op(2'b11, 4'h0, 0);
    check("clr_acc", acc, 0);
    check("clr_cout", cout, 0);
    check("clr_ovf", ovf, 0);
    check("clr_sticky", sticky, 0);
    do_op(2'b10, 4'h7, 0); do_op(2'b00, 4'h1, 1);
    check("satadd_acc", acc, 4'h7);
    check("satadd_ovf", ovf, 1);
    check("satadd_cout", cout, 0);
    do_op(2'b10, 4'h8, 0);
    check("load_keeps_sticky", sticky, 1);
    check("load_ovf", ovf, 0);
    do_op(2'b01, 4'h1, 1);
    check("satsub_acc", acc, 4'h8);
    check("satsub_ovf", ovf, 1);
    check("satsub_cout", cout, 1);
    do_op(2'b11, 4'h0, 0);
    do_op(2'b10, 4'h3, 0); do_op(2'b01, 4'h5, 0);
    check("sub35_acc", acc, 4'he);
    check("sub35_cout", cout, 0);
    check("sub35_ovf", ovf, 0);
    check("sub35_sticky", sticky, 0);
    do_op(2'b10, 4'hf, 0); do_op(2'b00, 4'h1, 0);
    check("addf1_acc", acc, 4'h0);
    check("addf1_cout", cout, 1);
    check("addf1_ovf", ovf, 0);
    // Start held high: one op only, and operand changes after the latch are ignored
    @(negedge clk);
    op = 2'b00; b = 4'h1; sat = 1'b0; start = 1'b1;
    pulses = 0; lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        check("held_busy", busy, 1);
        b = 4'h7;
      end
      if (done) begin
        pulses++;
        if (lat == 0) lat = i;
      end
    end
    check("held_pulses", pulses[7:0], 1);
    check("held_latency", lat[7:0], 2);
    check("held_acc", acc, 4'h1);
    @(negedge clk); start = 1'b0;
    // reset in EXEC aborts the op
    @(negedge clk);
    op = 2'b10; b = 4'h9; start = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", busy, 1);
    @(negedge clk); rst = 1'b1; start = 1'b0;
    @(negedge clk); rst = 1'b0;
    check("abort_acc", acc, 0);
    check("abort_busy_low", busy, 0);
    pulses = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("abort_no_done", pulses[7:0], 0);
    check("abort_acc_hold", acc, 0);
    do_op(2'b00, 4'h3, 0);
    check("post_abort_acc", acc, 4'h3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
